input_row_sequencer: RTL
========================

Name: input_row_sequencer

Overview:
- Sequences row reads from the input dual-port memory's 2048-bit PL read port: 64 rows of 64 x 32-bit words, 1-cycle registered read latency.
- On a start command, fetches a contiguous, wrapping range of rows and streams them to the matmul datapath over a valid/ready interface.
- A 2-entry output buffer absorbs memory read latency under backpressure.
- Sits between the memory's PL port and the matmul array front end; the AXI side of the memory is untouched.

Parameters:
- DATA_W, 2048, width of one memory row (mem_dout / out_data)
- ADDR_W, 6, row address width; the memory holds 2**ADDR_W rows
- CNT_W, 7, width of num_rows (ADDR_W+1, so a full 64-row sweep is expressible)

Ports:
- clk  in  1  single clock, shared with the memory PL port
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle command pulse, accepted only when busy=0
- base_row  in  ADDR_W  first row to read, sampled with accepted start
- num_rows  in  CNT_W  rows to read (0..64), sampled with accepted start
- busy  out  1  high from accepted start until the cycle done is asserted
- done  out  1  one-cycle pulse when the command is complete
- mem_en  out  1  read enable to memory port B (en_b); we_b is tied 0 externally
- mem_addr  out  ADDR_W  row address to memory port B (addr_b)
- mem_dout  in  DATA_W  memory port B read data, valid the cycle after mem_en
- out_valid  out  1  out_data holds a row
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_data  out  DATA_W  row data, word 0 in the MSBs (memory packing order)
- out_row  out  ADDR_W  address of the row in out_data
- out_last  out  1  out_data is the final row of the command

Behaviour:
- Reset: clears all state. busy=0, done=0, mem_en=0, mem_addr=0, out_valid=0, out_data=0, out_row=0, out_last=0. The buffer is emptied and in-flight reads are discarded. Reset mid-command abandons it with no done pulse.
- States:
  - IDLE: start accepted. If num_rows=0, go to FIN. Otherwise latch base_row, num_rows, set busy=1, go to ISSUE.
  - ISSUE: issue reads until issued count = num_rows, then go to DRAIN.
  - DRAIN: wait until the last row is handshaken, then go to FIN.
  - FIN: done=1 for one cycle, busy=0, return to IDLE.
- start while busy=1, or in FIN, is ignored.
- Issue rule: mem_en=1 in a cycle only if in ISSUE, rows remain, and (buffer occupancy + reads in flight) < 2. This guarantees no returned row is dropped.
- mem_addr = (base_row + issue_index) mod 2**ADDR_W. Wraps 63 -> 0 naturally by ADDR_W truncation.
- Capture: the cycle after mem_en, mem_dout is written into the buffer together with its address and a last flag (issue_index = num_rows-1).
- Output: out_* is driven from the buffer head and stays stable while out_valid && !out_ready. Simultaneous push and pop in the same cycle is legal; occupancy is unchanged.
- Latency with out_ready=1:
  - start sampled at edge E0;
  - mem_en first high in the cycle after E0;
  - first out_valid two cycles after that;
  - then one row per cycle.
- Backpressure: with out_ready=0, at most 2 reads are outstanding plus buffered. Issue resumes as soon as a pop frees a slot.
- done is asserted the cycle after the handshake of the out_last row. In the num_rows=0 case it is asserted the cycle after start, with busy=0 throughout and no mem_en.
- num_rows > 64 is out of range. It is clamped to 64.

Test Plan:
- start, base_row=0, num_rows=64, out_ready=1 -> mem_addr 0..63 on consecutive cycles; out_row 0..63 on consecutive cycles, first out_valid 3 cycles after start; out_last only on row 63; done one cycle after the final handshake; out_data matches preloaded memory rows.
- base_row=62, num_rows=4 -> out_row sequence 62, 63, 0, 1; out_last on row 1; exactly 4 mem_en cycles.
- num_rows=8, out_ready random ~50% -> all 8 rows delivered in order with no loss or duplication; out_data stable while stalled; never more than 2 rows buffered-plus-in-flight.
- num_rows=0 -> done pulse the cycle after start, busy stays 0, mem_en never asserted.
- start pulsed again while busy during a 16-row command -> ignored; exactly 16 rows and a single done.
- rst asserted after 5 rows of a 20-row command -> next cycle all outputs 0, no done. A new start with base_row=10, num_rows=2 then delivers rows 10 and 11 normally.

Source files
------------

// File: rtl/input_row_sequencer_if.sv
// input_row_sequencer_if: command, memory read port and row stream bundle
interface input_row_sequencer_if #(
    parameter int DATA_W = 2048,
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 7
);
    logic              start;
    logic [ADDR_W-1:0] base_row;
    logic [CNT_W-1:0]  num_rows;
    logic              busy;
    logic              done;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dout;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_row;
    logic              out_last;
    modport master (
        input  start, base_row, num_rows, mem_dout, out_ready,
        output busy, done, mem_en, mem_addr, out_valid, out_data, out_row, out_last
    );
    modport slave (
        output start, base_row, num_rows, mem_dout, out_ready,
        input  busy, done, mem_en, mem_addr, out_valid, out_data, out_row, out_last
    );
endinterface

// File: rtl/input_row_sequencer.sv
// input_row_sequencer: streams a wrapping range of memory rows through a 2-entry buffer
module input_row_sequencer #(
    parameter int DATA_W = 2048,
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 7
) (
    input logic                   clk,
    input logic                   rst,
    input_row_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
    state_t            state, state_nx;
    logic [ADDR_W-1:0] base_r;
    logic [CNT_W-1:0]  num_r, issued, num_clamp;
    logic              pend, pend_last;
    logic [ADDR_W-1:0] pend_row;
    logic [DATA_W-1:0] buf_data [2];
    logic [ADDR_W-1:0] buf_row [2];
    logic [1:0]        buf_last;
    logic              rd_ptr, wr_ptr, pop, issue;
    logic [1:0]        count;

    assign num_clamp     = bus.num_rows > CNT_W'(2**ADDR_W) ? CNT_W'(2**ADDR_W) : bus.num_rows;
    assign bus.out_valid = count != 2'd0;
    assign pop           = bus.out_valid && bus.out_ready;
    // a same-cycle pop frees its slot, which keeps one row per cycle at full rate
    assign issue         = state == ISSUE && issued != num_r &&
                           (count + {1'b0, pend} - {1'b0, pop}) < 2'd2;
    assign bus.mem_en    = issue;
    assign bus.mem_addr  = base_r + issued[ADDR_W-1:0];
    assign bus.out_data  = buf_data[rd_ptr];
    assign bus.out_row   = buf_row[rd_ptr];
    assign bus.out_last  = bus.out_valid && buf_last[rd_ptr];
    assign bus.busy      = state == ISSUE || state == DRAIN;
    assign bus.done      = state == FIN;

    always_comb begin
        state_nx = state;
        if (state == IDLE && bus.start) state_nx = num_clamp == '0 ? FIN : ISSUE;
        else if (state == ISSUE && issued == num_r) state_nx = DRAIN;
        else if (state == DRAIN && pop && bus.out_last) state_nx = FIN;
        else if (state == FIN) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            base_r      <= '0;
            num_r       <= '0;
            issued      <= '0;
            pend        <= 1'b0;
            pend_row    <= '0;
            pend_last   <= 1'b0;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_row[0]  <= '0;
            buf_row[1]  <= '0;
            buf_last    <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.start) begin
                base_r <= bus.base_row;
                num_r  <= num_clamp;
                issued <= '0;
            end else if (issue) begin
                issued <= issued + CNT_W'(1);
            end
            pend      <= issue;
            pend_row  <= bus.mem_addr;
            pend_last <= issued == num_r - CNT_W'(1);
            if (pend) begin
                buf_data[wr_ptr] <= bus.mem_dout;
                buf_row[wr_ptr]  <= pend_row;
                buf_last[wr_ptr] <= pend_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, pend} - {1'b0, pop};
        end
    end
endmodule
